dense_bias_unit: RTL and testbench

Parametrised, writable successor to the fixed dense-layer bias lookup table. It stores one signed bias per output neuron in a register bank loaded at run time. A streaming stage adds the bias to each incoming dense-layer accumulator, with a neuron index that advances automatically. It sits between the dense-layer MAC array and the argmax/classification stage.

---
 rtl/dense_bias_unit_if.sv | 31 +++
 rtl/dense_bias_unit.sv | 105 ++++++++++
 tb/tb_dense_bias_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_bias_unit_if.sv
// Bias-write, accumulator-in and result-out signals of dense_bias_unit.
// The master drives writes, accumulators and outReady; the slave is the unit.
interface dense_bias_unit_if #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned LENGTH_SIZE = 10
);
  localparam int unsigned ADR_SIZE = (LENGTH_SIZE > 1) ? $clog2(LENGTH_SIZE) : 1;

  logic                 wr;
  logic [ADR_SIZE-1:0]  wrAdr;
  logic [WORD_SIZE-1:0] wrData;
  logic                 start;
  logic                 inValid;
  logic                 inReady;
  logic [WORD_SIZE-1:0] inData;
  logic                 outValid;
  logic                 outReady;
  logic [WORD_SIZE-1:0] outData;
  logic [ADR_SIZE-1:0]  outIdx;
  logic                 outLast;

  modport master (
    output wr, wrAdr, wrData, start, inValid, inData, outReady,
    input  inReady, outValid, outData, outIdx, outLast
  );

  modport slave (
    input  wr, wrAdr, wrData, start, inValid, inData, outReady,
    output inReady, outValid, outData, outIdx, outLast
  );
endinterface

// File: rtl/dense_bias_unit.sv
// Writable per-neuron bias bank plus a two-stage streaming adder with auto-advancing neuron index.
// Define BIAS_SAT_EN to saturate the sum instead of wrapping it.
module dense_bias_unit #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned LENGTH_SIZE = 10
) (
  input logic              clk,
  input logic              rst,
  dense_bias_unit_if.slave bus
);
  localparam int unsigned ADR_SIZE = (LENGTH_SIZE > 1) ? $clog2(LENGTH_SIZE) : 1;
  localparam logic [ADR_SIZE-1:0] LastIdx = ADR_SIZE'(LENGTH_SIZE - 1);

  logic [WORD_SIZE-1:0] bias_q [LENGTH_SIZE];
  logic [ADR_SIZE-1:0]  idx_q, idx_d, eff;
  logic                 stall, accept;

  logic                 s1_valid_q;
  logic [WORD_SIZE-1:0] s1_data_q, s1_bias_q;
  logic [ADR_SIZE-1:0]  s1_idx_q;

  logic                 s2_valid_q;
  logic [WORD_SIZE-1:0] s2_data_q;
  logic [ADR_SIZE-1:0]  s2_idx_q;
  logic                 s2_last_q;
  logic [WORD_SIZE-1:0] sum;

  assign stall       = s2_valid_q & ~bus.outReady;
  assign accept      = bus.inValid & ~stall;
  assign eff         = bus.start ? '0 : idx_q;
  assign bus.inReady = ~stall;

  assign bus.outValid = s2_valid_q;
  assign bus.outData  = s2_data_q;
  assign bus.outIdx   = s2_idx_q;
  assign bus.outLast  = s2_last_q;

`ifdef BIAS_SAT_EN
  logic [WORD_SIZE:0] sum_wide;
  assign sum_wide = {s1_data_q[WORD_SIZE-1], s1_data_q} + {s1_bias_q[WORD_SIZE-1], s1_bias_q};

  // Overflow iff the extra sign bit disagrees with the result's sign bit.
  always_comb begin
    sum = sum_wide[WORD_SIZE-1:0];
    if (sum_wide[WORD_SIZE] != sum_wide[WORD_SIZE-1]) begin
      sum = {sum_wide[WORD_SIZE], {(WORD_SIZE-1){~sum_wide[WORD_SIZE]}}};
    end
  end
`else
  assign sum = s1_data_q + s1_bias_q;
`endif

  // Bank is read in the accept cycle, so a same-cycle write lands only for later elements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LENGTH_SIZE; i++) begin
        bias_q[i] <= '0;
      end
    end else if (bus.wr && (bus.wrAdr <= LastIdx)) begin
      bias_q[bus.wrAdr] <= bus.wrData;
    end
  end

  // A stall freezes the index even if start is asserted.
  always_comb begin
    idx_d = idx_q;
    if (!stall) begin
      if (accept) begin
        idx_d = (eff == LastIdx) ? '0 : eff + 1'b1;
      end else if (bus.start) begin
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_bias_q  <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_data_q <= bus.inData;
          s1_idx_q  <= eff;
          s1_bias_q <= bias_q[eff];
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= sum;
          s2_idx_q  <= s1_idx_q;
          s2_last_q <= (s1_idx_q == LastIdx);
        end
      end
    end
  end
endmodule

// File: tb/tb_dense_bias_unit.sv
// Bench for dense_bias_unit: directed scenarios plus random traffic, checked against a
// queue-based model of the bias table and neuron indexing.
module tb_dense_bias_unit;
  localparam int unsigned W = 32;
  localparam int unsigned L = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dense_bias_unit_if #(.WORD_SIZE(W), .LENGTH_SIZE(L)) bus ();

  dense_bias_unit #(.WORD_SIZE(W), .LENGTH_SIZE(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    int           cyc;
  } exp_t;

  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           m_idx = 0;
  logic [W-1:0] bias_m [L];
  exp_t         q [$];
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic [3:0]   prev_idx;
  logic         prev_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] reduce(input longint s);
`ifdef BIAS_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return W'(s);
  endfunction

  // Inputs are set at negedge; sample just after, run the model, then advance one clock.
  task automatic step();
    bit   acc, fire, stall;
    int   eff;
    exp_t e;
    #1;
    acc   = bus.inValid && bus.inReady;
    fire  = bus.outValid && bus.outReady;
    stall = bus.outValid && !bus.outReady;
    chk("in_ready", 64'(bus.inReady), 64'(!stall));
    if (prev_stall) begin
      chk("hold_data", 64'(bus.outData), 64'(prev_data));
      chk("hold_idx", 64'(bus.outIdx), 64'(prev_idx));
      chk("hold_last", 64'(bus.outLast), 64'(prev_last));
    end
    if (fire) begin
      chk("out_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", 64'(bus.outData), 64'(e.data));
        chk("out_idx", 64'(bus.outIdx), 64'(e.idx));
        chk("out_last", 64'(bus.outLast), 64'(e.idx == L - 1));
        chk("out_latency", 64'(cyc - e.cyc >= 2), 64'd1);
      end
    end
    if (acc) begin
      eff    = bus.start ? 0 : m_idx;
      e.data = reduce(longint'($signed(bias_m[eff])) + longint'($signed(bus.inData)));
      e.idx  = eff;
      e.cyc  = cyc;
      q.push_back(e);
      m_idx = (eff == L - 1) ? 0 : eff + 1;
    end else if (bus.start && !stall) begin
      m_idx = 0;
    end
    if (bus.wr && bus.wrAdr < L) bias_m[bus.wrAdr] = bus.wrData;
    prev_stall = stall;
    prev_data  = bus.outData;
    prev_idx   = bus.outIdx;
    prev_last  = bus.outLast;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wr      = 1'b0;
    bus.start   = 1'b0;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(bus.outValid), 64'd0);
  endtask

  task automatic write_bias(input int adr, input logic [W-1:0] val);
    idle();
    bus.wr     = 1'b1;
    bus.wrAdr  = 4'(adr);
    bus.wrData = val;
    step();
    bus.wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < L; i++) bias_m[i] = '0;
    rst = 1'b1;
    idle();
    bus.wrAdr  = '0;
    bus.wrData = '0;
    bus.inData = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.inReady), 64'd1);
    chk("rst_out_valid", 64'(bus.outValid), 64'd0);
    chk("rst_out_data", 64'(bus.outData), 64'd0);
    chk("rst_out_idx", 64'(bus.outIdx), 64'd0);
    chk("rst_out_last", 64'(bus.outLast), 64'd0);
    @(negedge clk);

    // Load 1..10, then out-of-range writes that must be ignored.
    for (int i = 0; i < L; i++) write_bias(i, W'(i + 1));
    for (int i = L; i < 16; i++) write_bias(i, 32'hDEAD_0000 + W'(i));

    // Steady stream of 100s, with exact two-edge latency on the first element.
    idle();
    bus.inValid = 1'b1;
    bus.inData  = 32'd100;
    step();
    chk("lat_edge1", 64'(bus.outValid), 64'd0);
    step();
    chk("lat_edge2", 64'(bus.outValid), 64'd1);
    for (int i = 2; i < 10; i++) step();
    drain();

    // Index wrap over 15 inputs, start on the 13th.
    for (int i = 0; i < 15; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = W'(i * 1000);
      bus.start   = (i == 12);
      step();
    end
    drain();

    // Backpressure for three cycles mid-stream.
    for (int k = 0; k < 10; k++) begin
      bus.inValid  = 1'b1;
      bus.inData   = W'(k * 7);
      bus.outReady = !(k >= 3 && k < 6);
      if (k >= 3 && k < 6) begin
        #1;
        chk("stall_in_ready", 64'(bus.inReady), 64'd0);
      end
      step();
    end
    drain();

    // Same-cycle write to bias[3] during the idx-3 accept; the next pass sees it.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        bus.inValid = 1'b1;
        bus.inData  = '0;
        bus.start   = (i == 0);
        bus.wr      = (pass == 0 && i == 3);
        bus.wrAdr   = 4'd3;
        bus.wrData  = 32'd50;
        step();
      end
      bus.wr = 1'b0;
      drain();
    end

    // Overflow corners.
    write_bias(0, 32'h0000_0020);
    write_bias(1, 32'hFFFF_FFFF);
    bus.inValid = 1'b1;
    bus.start   = 1'b1;
    bus.inData  = 32'h7FFF_FFF0;
    step();
    bus.start  = 1'b0;
    bus.inData = 32'h8000_0000;
    step();
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.inValid  = ($urandom_range(0, 3) != 0);
      bus.outReady = ($urandom_range(0, 3) != 0);
      bus.start    = ($urandom_range(0, 15) == 0);
      bus.wr       = ($urandom_range(0, 3) == 0);
      bus.wrAdr    = 4'($urandom_range(0, 15));
      bus.wrData   = $urandom;
      case ($urandom_range(0, 3))
        0:       bus.inData = 32'h7FFF_FFF0 + W'($urandom_range(0, 31));
        1:       bus.inData = 32'h8000_0000 + W'($urandom_range(0, 31));
        default: bus.inData = $urandom;
      endcase
      step();
    end
    drain();

    // Asynchronous reset with two elements in flight.
    write_bias(0, 32'd123);
    bus.inValid = 1'b1;
    bus.inData  = 32'd5;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.outValid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.inReady), 64'd1);
    chk("mid_rst_out_data", 64'(bus.outData), 64'd0);
    q.delete();
    m_idx = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < L; i++) bias_m[i] = '0;
    idle();
    @(negedge clk);
    rst = 1'b0;
    bus.inValid = 1'b1;
    bus.inData  = 32'd7;
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
